load_store_buffer: RTL and testbench
====================================

# load_store_buffer

In-order load/store queue sitting between instruction issue, the reorder buffer and the memory controller. Holds issued memory instructions, captures missing base/data operands from result broadcasts, and executes loads at the head as soon as operands are ready, returning data and ROB tag to the ROB. Stores execute only after the ROB commits them, and uncommitted entries are flushed on a misprediction.

## Interface
Parameters:
- ROB_WIDTH, 4, ROB tag width (matches reorder_buffer)
- LSB_WIDTH, 3, queue index width
- LSB_SIZE, 2**LSB_WIDTH, queue depth

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  reset, synchronous, active-high
- rdy_in  in  1  pause when low
- clear_signal  in  1  flush from ROB on misprediction
- issue_signal  in  1  push a new entry
- issue_is_store  in  1  1 = store, 0 = load
- issue_funct3  in  3  width/sign code (RV32I LB/LH/LW/LBU/LHU, SB/SH/SW)
- issue_rob_tag  in  ROB_WIDTH  ROB line of the instruction
- issue_offset  in  32  sign-extended immediate
- issue_rs1_ready, issue_rs2_ready  in  1  operand already valid
- issue_rs1_value, issue_rs2_value  in  32  operand value if ready
- issue_rs1_tag, issue_rs2_tag  in  ROB_WIDTH  producer tag if not ready
- alu_done  in  1;  alu_value  in  32;  alu_tag  in  ROB_WIDTH  ALU broadcast
- commit_done  in  1;  commit_tag  in  ROB_WIDTH  store commit from ROB
- load_done  out  1  one-cycle load-result pulse
- load_value  out  32  extended load data
- load_tag  out  ROB_WIDTH  ROB tag of the load
- mem_req  out  1  memory request valid
- mem_we  out  1  1 = write
- mem_addr  out  32  byte address (rs1 + offset)
- mem_wdata  out  32  store data (rs2)
- mem_funct3  out  3  access width
- mem_ack  in  1  request complete; mem_rdata valid this cycle
- mem_rdata  in  32  raw read data, right-aligned
- full  out  1  count == LSB_SIZE

## Operation
- Circular queue with front/rear pointers and count. Each entry holds: is_store, funct3, rob_tag, offset, rs1/rs2 value+tag+ready, and a committed flag.
- Issue while full is ignored. Issue and pop in the same cycle are both honored.
- Snooping: every cycle each not-ready operand whose tag equals alu_tag (alu_done) or load_tag (load_done) captures the value. Issue-cycle bypass: if an issuing operand is not ready and its tag matches that cycle's broadcast, it is stored ready with the broadcast value.
- commit_done sets committed on the store entry whose rob_tag equals commit_tag and increments committed_cnt.
- FSM states:
  - IDLE: head is a load with rs1 ready, or a committed store with rs1 and rs2 ready -> drive mem_req and go to BUSY.
  - BUSY: hold request until mem_ack -> pop head. For a load, register load_done with funct3-extended data, then -> IDLE. Otherwise go to DISCARD if the load was flushed meanwhile.
  - DISCARD: wait for mem_ack of the aborted load, emit nothing, -> IDLE.
- Extension: LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- clear_signal: all uncommitted entries are dropped. Committed stores always form a head prefix, so rear <= front + committed_cnt and count <= committed_cnt. An in-flight committed store completes normally. An in-flight load moves to DISCARD. A load_done due that cycle is suppressed. Issue in the clear cycle is ignored.
- rdy_in low: all state frozen, load_done forced 0, mem_req and mem outputs held.

## Timing
- Reset: load_done=0, load_value=0, load_tag=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_funct3=0, full=0. Queue empty, committed_cnt=0, state IDLE.
- mem_req rises the cycle after the head becomes eligible. mem_addr, mem_wdata, mem_we and mem_funct3 stay stable until mem_ack.
- load_done pulses for exactly one cycle, in the cycle after mem_ack. The entry is freed in the mem_ack cycle.
- Minimum load latency: issue with rs1 ready -> mem_req at +1 -> with a 1-cycle ack, load_done at +3.
- Pointers wrap modulo LSB_SIZE. full is combinational from count.

## Structure
- Shared package lsb_pkg holds: funct3 constants (LB=000, LH=001, LW=010, LBU=100, LHU=101, SB=000, SH=001, SW=010), the FSM state encoding, and the entry field widths.
- Sub-module load_extend: combinational funct3 + raw data -> sign- or zero-extended 32-bit result.

## Test plan
- LW at offset 4 with rs1 ready = 0x100, mem_rdata = 0x8000_00FF -> mem_addr = 0x104, load_done one cycle with value 0x8000_00FF and the issued tag.
- LB then LBU on mem_rdata 0x0000_0080 -> load_value 0xFFFF_FF80, then 0x0000_0080.
- SW with rs2 tag 5 not ready; alu_done tag 5 value 0xDEAD_BEEF, then commit_done -> mem_we=1, mem_wdata=0xDEAD_BEEF only after commit.
- Fill 8 entries -> full=1, a 9th issue is ignored. Pop one -> full=0, rear wraps to 0.
- One committed store plus two loads, load in flight, clear_signal -> store performed, no load_done, count=0 after the store.
- Issue in the same cycle as a matching alu_done broadcast -> operand captured, load proceeds without a further broadcast.

Source files
------------

// File: rtl/lsb_pkg.sv
// lsb_pkg: funct3 codes, FSM encoding and entry field widths shared by the load/store buffer.
package lsb_pkg;
  localparam int XLEN = 32;
  localparam int F3_BITS = 3;
  localparam logic [F3_BITS-1:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
  localparam logic [F3_BITS-1:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DISCARD = 2'd2} lsb_state_t;
endpackage

// File: rtl/load_extend.sv
// load_extend: sign- or zero-extends right-aligned load data according to funct3.
module load_extend
  import lsb_pkg::*;
(
  input  logic [F3_BITS-1:0] funct3,
  input  logic [XLEN-1:0]    raw,
  output logic [XLEN-1:0]    value
);
  always_comb
    value = funct3 == LB  ? {{24{raw[7]}}, raw[7:0]} :
            funct3 == LH  ? {{16{raw[15]}}, raw[15:0]} :
            funct3 == LBU ? {24'b0, raw[7:0]} :
            funct3 == LHU ? {16'b0, raw[15:0]} : raw;
endmodule

// File: rtl/load_store_buffer.sv
// load_store_buffer: in-order load/store queue with operand snooping, commit-gated stores and flush.
module load_store_buffer
  import lsb_pkg::*;
#(
  parameter int ROB_WIDTH = 4,
  parameter int LSB_WIDTH = 3,
  parameter int LSB_SIZE  = 2 ** LSB_WIDTH
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clear_signal,
  input  logic                 issue_signal,
  input  logic                 issue_is_store,
  input  logic [F3_BITS-1:0]   issue_funct3,
  input  logic [ROB_WIDTH-1:0] issue_rob_tag,
  input  logic [XLEN-1:0]      issue_offset,
  input  logic                 issue_rs1_ready,
  input  logic                 issue_rs2_ready,
  input  logic [XLEN-1:0]      issue_rs1_value,
  input  logic [XLEN-1:0]      issue_rs2_value,
  input  logic [ROB_WIDTH-1:0] issue_rs1_tag,
  input  logic [ROB_WIDTH-1:0] issue_rs2_tag,
  input  logic                 alu_done,
  input  logic [XLEN-1:0]      alu_value,
  input  logic [ROB_WIDTH-1:0] alu_tag,
  input  logic                 commit_done,
  input  logic [ROB_WIDTH-1:0] commit_tag,
  output logic                 load_done,
  output logic [XLEN-1:0]      load_value,
  output logic [ROB_WIDTH-1:0] load_tag,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [XLEN-1:0]      mem_addr,
  output logic [XLEN-1:0]      mem_wdata,
  output logic [F3_BITS-1:0]   mem_funct3,
  input  logic                 mem_ack,
  input  logic [XLEN-1:0]      mem_rdata,
  output logic                 full
);
  logic                 e_store [LSB_SIZE];
  logic                 e_com   [LSB_SIZE];
  logic [F3_BITS-1:0]   e_f3    [LSB_SIZE];
  logic [ROB_WIDTH-1:0] e_tag   [LSB_SIZE];
  logic [XLEN-1:0]      e_off   [LSB_SIZE];
  logic                 e_r1    [LSB_SIZE];
  logic                 e_r2    [LSB_SIZE];
  logic [XLEN-1:0]      e_v1    [LSB_SIZE];
  logic [XLEN-1:0]      e_v2    [LSB_SIZE];
  logic [ROB_WIDTH-1:0] e_t1    [LSB_SIZE];
  logic [ROB_WIDTH-1:0] e_t2    [LSB_SIZE];
  logic [LSB_WIDTH-1:0] front, rear, front_nx, commit_idx;
  logic [LSB_WIDTH:0]   count, committed_cnt, cc_nx;
  lsb_state_t           state, state_nx;
  logic                 load_done_q, head_ok, start, pop, issue_ok, commit_hit;
  logic [XLEN-1:0]      ext_value;
  function automatic logic hit(input logic [ROB_WIDTH-1:0] t);
    return (alu_done && t == alu_tag) || (load_done && t == load_tag);
  endfunction
  function automatic logic [XLEN-1:0] hval(input logic [ROB_WIDTH-1:0] t);
    return (alu_done && t == alu_tag) ? alu_value : load_value;
  endfunction
  function automatic logic in_q(input logic [LSB_WIDTH-1:0] idx);
    logic [LSB_WIDTH-1:0] rel;
    rel = idx - front;
    return {1'b0, rel} < count;
  endfunction
  load_extend u_ext (.funct3(mem_funct3), .raw(mem_rdata), .value(ext_value));
  assign full = count == (LSB_WIDTH+1)'(LSB_SIZE);
  assign load_done = load_done_q && rdy_in;
  always_comb begin
    commit_hit = 1'b0;
    commit_idx = '0;
    for (int i = 0; i < LSB_SIZE; i++)
      if (commit_done && e_store[i] && !e_com[i] && e_tag[i] == commit_tag && in_q(LSB_WIDTH'(i))) begin
        commit_hit = 1'b1;
        commit_idx = LSB_WIDTH'(i);
      end
  end
  always_ff @(posedge clk_in)
    if (rst_in) state <= IDLE;
    else if (rdy_in) state <= state_nx;
  // A flushed load still owes the memory an ack, so it is drained in DISCARD.
  always_comb
    state_nx = state == IDLE ? (start ? BUSY : IDLE) :
               state == BUSY ? (mem_ack ? IDLE : (clear_signal && !e_store[front]) ? DISCARD : BUSY) :
               (mem_ack ? IDLE : DISCARD);
  always_comb begin
    head_ok  = count != 0 && e_r1[front] && (!e_store[front] || (e_com[front] && e_r2[front]));
    start    = state == IDLE && head_ok && !(clear_signal && !e_store[front]);
    pop      = state == BUSY && mem_ack;
    issue_ok = issue_signal && !full && !clear_signal;
    front_nx = front + LSB_WIDTH'(pop);
    cc_nx    = committed_cnt + (LSB_WIDTH+1)'(commit_hit) - (LSB_WIDTH+1)'(pop && e_store[front]);
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      front         <= '0;
      rear          <= '0;
      count         <= '0;
      committed_cnt <= '0;
    end else if (rdy_in) begin
      front         <= front_nx;
      committed_cnt <= cc_nx;
      rear          <= clear_signal ? front_nx + cc_nx[LSB_WIDTH-1:0] : rear + LSB_WIDTH'(issue_ok);
      count         <= clear_signal ? cc_nx : count + (LSB_WIDTH+1)'(issue_ok) - (LSB_WIDTH+1)'(pop);
      for (int i = 0; i < LSB_SIZE; i++) begin
        if (!e_r1[i] && hit(e_t1[i])) begin
          e_r1[i] <= 1'b1;
          e_v1[i] <= hval(e_t1[i]);
        end
        if (!e_r2[i] && hit(e_t2[i])) begin
          e_r2[i] <= 1'b1;
          e_v2[i] <= hval(e_t2[i]);
        end
      end
      if (commit_hit) e_com[commit_idx] <= 1'b1;
      if (issue_ok) begin
        e_store[rear] <= issue_is_store;
        e_com[rear]   <= 1'b0;
        e_f3[rear]    <= issue_funct3;
        e_tag[rear]   <= issue_rob_tag;
        e_off[rear]   <= issue_offset;
        e_t1[rear]    <= issue_rs1_tag;
        e_t2[rear]    <= issue_rs2_tag;
        e_r1[rear]    <= issue_rs1_ready || hit(issue_rs1_tag);
        e_r2[rear]    <= issue_rs2_ready || hit(issue_rs2_tag);
        e_v1[rear]    <= issue_rs1_ready ? issue_rs1_value : hval(issue_rs1_tag);
        e_v2[rear]    <= issue_rs2_ready ? issue_rs2_value : hval(issue_rs2_tag);
      end
    end
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      load_done_q <= 1'b0;
      load_value  <= '0;
      load_tag    <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_funct3  <= '0;
    end else if (rdy_in) begin
      load_done_q <= pop && !e_store[front] && !clear_signal;
      if (pop && !e_store[front]) begin
        load_value <= ext_value;
        load_tag   <= e_tag[front];
      end
      if (start) begin
        mem_req    <= 1'b1;
        mem_we     <= e_store[front];
        mem_addr   <= e_v1[front] + e_off[front];
        mem_wdata  <= e_v2[front];
        mem_funct3 <= e_f3[front];
      end else if (mem_ack && state != IDLE) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_load_store_buffer.sv
// tb_load_store_buffer: directed scenarios for the load/store buffer with hand-computed expectations.
module tb_load_store_buffer;
  logic        clk_in = 1'b0, rst_in, rdy_in, clear_signal, issue_signal, issue_is_store;
  logic [2:0]  issue_funct3, mem_funct3;
  logic [3:0]  issue_rob_tag, issue_rs1_tag, issue_rs2_tag, alu_tag, commit_tag, load_tag;
  logic [31:0] issue_offset, issue_rs1_value, issue_rs2_value, alu_value, load_value;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        issue_rs1_ready, issue_rs2_ready, alu_done, commit_done, load_done;
  logic        mem_req, mem_we, mem_ack, full;
  int tests = 0, fails = 0;
  load_store_buffer dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_signal(clear_signal),
    .issue_signal(issue_signal), .issue_is_store(issue_is_store), .issue_funct3(issue_funct3),
    .issue_rob_tag(issue_rob_tag), .issue_offset(issue_offset),
    .issue_rs1_ready(issue_rs1_ready), .issue_rs2_ready(issue_rs2_ready),
    .issue_rs1_value(issue_rs1_value), .issue_rs2_value(issue_rs2_value),
    .issue_rs1_tag(issue_rs1_tag), .issue_rs2_tag(issue_rs2_tag),
    .alu_done(alu_done), .alu_value(alu_value), .alu_tag(alu_tag),
    .commit_done(commit_done), .commit_tag(commit_tag),
    .load_done(load_done), .load_value(load_value), .load_tag(load_tag),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_funct3(mem_funct3), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .full(full)
  );
  always #5 clk_in = ~clk_in;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end
  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask
  task automatic reset_dut;
    rst_in = 1'b1; rdy_in = 1'b1; clear_signal = 1'b0; issue_signal = 1'b0; issue_is_store = 1'b0;
    issue_funct3 = 3'b0; issue_rob_tag = 4'd0; issue_offset = 32'd0;
    issue_rs1_ready = 1'b0; issue_rs2_ready = 1'b0; issue_rs1_value = 32'd0; issue_rs2_value = 32'd0;
    issue_rs1_tag = 4'd0; issue_rs2_tag = 4'd0; alu_done = 1'b0; alu_value = 32'd0; alu_tag = 4'd0;
    commit_done = 1'b0; commit_tag = 4'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
    tick;
    tick;
    rst_in = 1'b0;
  endtask
  task automatic set_issue(input logic st, input logic [2:0] f3, input logic [3:0] tag, input logic [31:0] off,
                           input logic r1, input logic [31:0] v1, input logic [3:0] t1,
                           input logic r2, input logic [31:0] v2, input logic [3:0] t2);
    issue_signal = 1'b1; issue_is_store = st; issue_funct3 = f3; issue_rob_tag = tag; issue_offset = off;
    issue_rs1_ready = r1; issue_rs1_value = v1; issue_rs1_tag = t1;
    issue_rs2_ready = r2; issue_rs2_value = v2; issue_rs2_tag = t2;
  endtask
  task automatic issue(input logic st, input logic [2:0] f3, input logic [3:0] tag, input logic [31:0] off,
                       input logic r1, input logic [31:0] v1, input logic [3:0] t1,
                       input logic r2, input logic [31:0] v2, input logic [3:0] t2);
    set_issue(st, f3, tag, off, r1, v1, t1, r2, v2, t2);
    tick;
    issue_signal = 1'b0;
  endtask
  task automatic wait_req(input string name);
    for (int n = 0; n < 20 && !mem_req; n++) tick;
    if (!mem_req) begin
      tests++; fails++;
      $display("FAIL %s: mem_req got 0 required 1 within 20 cycles", name);
    end
  endtask
  task automatic ack(input logic [31:0] rdata);
    mem_ack = 1'b1; mem_rdata = rdata;
    tick;
    mem_ack = 1'b0;
  endtask
  task automatic test_reset;
    reset_dut;
    tests++; if (load_done !== 1'b0) begin fails++; $display("FAIL reset_load_done: got %b required 0", load_done); end
    tests++; if (load_value !== 32'd0) begin fails++; $display("FAIL reset_load_value: got %h required 0", load_value); end
    tests++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin fails++; $display("FAIL reset_mem_ctl: got req=%b we=%b required 0 0", mem_req, mem_we); end
    tests++; if (mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin fails++; $display("FAIL reset_mem_data: got %h %h required 0 0", mem_addr, mem_wdata); end
    tests++; if (full !== 1'b0) begin fails++; $display("FAIL reset_full: got %b required 0", full); end
  endtask
  task automatic test_lw;
    issue(1'b0, 3'b010, 4'd3, 32'd4, 1'b1, 32'h100, 4'd0, 1'b0, 32'd0, 4'd0);
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL lw_req_early: got %b required 0", mem_req); end
    tick;
    tests++; if (mem_req !== 1'b1) begin fails++; $display("FAIL lw_req_latency: got %b required 1", mem_req); end
    tests++; if (mem_addr !== 32'h104 || mem_we !== 1'b0) begin fails++; $display("FAIL lw_addr: got %h we=%b required 104 we=0", mem_addr, mem_we); end
    tick;
    tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h104) begin fails++; $display("FAIL lw_hold: got req=%b %h required 1 104", mem_req, mem_addr); end
    ack(32'h8000_00FF);
    tests++; if (load_done !== 1'b1) begin fails++; $display("FAIL lw_done: got %b required 1", load_done); end
    tests++; if (load_value !== 32'h8000_00FF || load_tag !== 4'd3) begin fails++; $display("FAIL lw_value: got %h tag %0d required 800000ff tag 3", load_value, load_tag); end
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL lw_req_drop: got %b required 0", mem_req); end
    tick;
    tests++; if (load_done !== 1'b0) begin fails++; $display("FAIL lw_pulse: got %b required 0", load_done); end
  endtask
  task automatic test_lb_lbu;
    issue(1'b0, 3'b000, 4'd1, 32'd0, 1'b1, 32'h200, 4'd0, 1'b0, 32'd0, 4'd0);
    issue(1'b0, 3'b100, 4'd2, 32'd1, 1'b1, 32'h200, 4'd0, 1'b0, 32'd0, 4'd0);
    wait_req("lb_req");
    tests++; if (mem_funct3 !== 3'b000 || mem_addr !== 32'h200) begin fails++; $display("FAIL lb_req: got f3=%b %h required 000 200", mem_funct3, mem_addr); end
    ack(32'h0000_0080);
    tests++; if (load_done !== 1'b1 || load_value !== 32'hFFFF_FF80 || load_tag !== 4'd1) begin fails++; $display("FAIL lb_value: got %b %h tag %0d required 1 ffffff80 tag 1", load_done, load_value, load_tag); end
    wait_req("lbu_req");
    tests++; if (mem_funct3 !== 3'b100 || mem_addr !== 32'h201) begin fails++; $display("FAIL lbu_req: got f3=%b %h required 100 201", mem_funct3, mem_addr); end
    ack(32'h0000_0080);
    tests++; if (load_done !== 1'b1 || load_value !== 32'h0000_0080 || load_tag !== 4'd2) begin fails++; $display("FAIL lbu_value: got %b %h tag %0d required 1 00000080 tag 2", load_done, load_value, load_tag); end
  endtask
  task automatic test_store_commit;
    issue(1'b1, 3'b010, 4'd6, 32'd8, 1'b1, 32'h300, 4'd0, 1'b0, 32'd0, 4'd5);
    tick;
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL sw_wait_operand: got req %b required 0", mem_req); end
    alu_done = 1'b1; alu_tag = 4'd5; alu_value = 32'hDEAD_BEEF;
    tick;
    alu_done = 1'b0;
    tick;
    tick;
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL sw_wait_commit: got req %b required 0", mem_req); end
    commit_done = 1'b1; commit_tag = 4'd6;
    tick;
    commit_done = 1'b0;
    wait_req("sw_req");
    tests++; if (mem_we !== 1'b1 || mem_wdata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL sw_data: got we=%b %h required 1 deadbeef", mem_we, mem_wdata); end
    tests++; if (mem_addr !== 32'h308 || mem_funct3 !== 3'b010) begin fails++; $display("FAIL sw_addr: got %h f3=%b required 308 010", mem_addr, mem_funct3); end
    ack(32'h0);
    tests++; if (load_done !== 1'b0 || mem_req !== 1'b0) begin fails++; $display("FAIL sw_done: got load_done=%b req=%b required 0 0", load_done, mem_req); end
  endtask
  task automatic test_full;
    reset_dut;
    for (int i = 0; i < 8; i++) issue(1'b0, 3'b010, 4'(i), 32'(4 * i), 1'b0, 32'd0, 4'd9, 1'b0, 32'd0, 4'd0);
    tests++; if (full !== 1'b1) begin fails++; $display("FAIL full_set: got %b required 1", full); end
    issue(1'b0, 3'b010, 4'd10, 32'd0, 1'b1, 32'h999, 4'd0, 1'b0, 32'd0, 4'd0);
    tests++; if (full !== 1'b1 || mem_req !== 1'b0) begin fails++; $display("FAIL full_ignore: got full=%b req=%b required 1 0", full, mem_req); end
    alu_done = 1'b1; alu_tag = 4'd9; alu_value = 32'h400;
    tick;
    alu_done = 1'b0;
    wait_req("full_req0");
    tests++; if (mem_addr !== 32'h400 || full !== 1'b1) begin fails++; $display("FAIL full_head: got %h full=%b required 400 1", mem_addr, full); end
    ack(32'd0);
    tests++; if (full !== 1'b0 || load_tag !== 4'd0) begin fails++; $display("FAIL full_pop: got full=%b tag %0d required 0 tag 0", full, load_tag); end
    for (int i = 1; i < 8; i++) begin
      wait_req("full_drain_req");
      tests++; if (mem_addr !== 32'h400 + 32'(4 * i)) begin fails++; $display("FAIL full_drain_addr: got %h required %h", mem_addr, 32'h400 + 32'(4 * i)); end
      ack(32'(i));
      tests++; if (load_done !== 1'b1 || load_tag !== 4'(i) || load_value !== 32'(i)) begin fails++; $display("FAIL full_drain: got %b tag %0d %h required 1 tag %0d %h", load_done, load_tag, load_value, i, i); end
    end
    for (int n = 0; n < 5; n++) tick;
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL full_ninth_dropped: got req %b addr %h required 0", mem_req, mem_addr); end
  endtask
  task automatic test_clear;
    int seen;
    reset_dut;
    issue(1'b1, 3'b010, 4'd1, 32'd0, 1'b1, 32'h500, 4'd0, 1'b1, 32'h11, 4'd0);
    issue(1'b0, 3'b010, 4'd2, 32'd0, 1'b1, 32'h600, 4'd0, 1'b0, 32'd0, 4'd0);
    issue(1'b0, 3'b010, 4'd3, 32'd0, 1'b1, 32'h700, 4'd0, 1'b0, 32'd0, 4'd0);
    commit_done = 1'b1; commit_tag = 4'd1;
    tick;
    commit_done = 1'b0;
    wait_req("clr_store_req");
    clear_signal = 1'b1;
    tick;
    clear_signal = 1'b0;
    tests++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h500 || mem_wdata !== 32'h11) begin fails++; $display("FAIL clr_store_kept: got req=%b we=%b %h %h required 1 1 500 11", mem_req, mem_we, mem_addr, mem_wdata); end
    ack(32'd0);
    seen = 0;
    for (int n = 0; n < 6; n++) begin
      if (mem_req || load_done) seen++;
      tick;
    end
    tests++; if (seen !== 0) begin fails++; $display("FAIL clr_loads_dropped: got %0d active cycles required 0", seen); end
    issue(1'b0, 3'b010, 4'd4, 32'd0, 1'b1, 32'h800, 4'd0, 1'b0, 32'd0, 4'd0);
    wait_req("clr_load_req");
    set_issue(1'b0, 3'b010, 4'd5, 32'd0, 1'b1, 32'h880, 4'd0, 1'b0, 32'd0, 4'd0);
    clear_signal = 1'b1;
    tick;
    clear_signal = 1'b0; issue_signal = 1'b0;
    tick;
    tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h800) begin fails++; $display("FAIL clr_discard_hold: got req=%b %h required 1 800", mem_req, mem_addr); end
    ack(32'h1234);
    tests++; if (load_done !== 1'b0 || mem_req !== 1'b0) begin fails++; $display("FAIL clr_discard: got load_done=%b req=%b required 0 0", load_done, mem_req); end
    seen = 0;
    for (int n = 0; n < 5; n++) begin
      if (mem_req || load_done) seen++;
      tick;
    end
    tests++; if (seen !== 0) begin fails++; $display("FAIL clr_issue_ignored: got %0d active cycles required 0", seen); end
  endtask
  task automatic test_bypass;
    set_issue(1'b0, 3'b010, 4'd8, 32'h10, 1'b0, 32'd0, 4'd12, 1'b0, 32'd0, 4'd0);
    alu_done = 1'b1; alu_tag = 4'd12; alu_value = 32'h900;
    tick;
    issue_signal = 1'b0; alu_done = 1'b0;
    wait_req("bypass_req");
    tests++; if (mem_addr !== 32'h910) begin fails++; $display("FAIL bypass_addr: got %h required 910", mem_addr); end
    ack(32'h55);
    tests++; if (load_done !== 1'b1 || load_value !== 32'h55 || load_tag !== 4'd8) begin fails++; $display("FAIL bypass_value: got %b %h tag %0d required 1 55 tag 8", load_done, load_value, load_tag); end
  endtask
  initial begin
    test_reset;
    test_lw;
    test_lb_lbu;
    test_store_commit;
    test_full;
    test_clear;
    test_bypass;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
